embedded_io_hd_cell: RTL and testbench
======================================

EMBEDDED_IO_HD_CELL -- requirements
Module: embedded_io_hd_cell

Interface
REQ-001 Parameter CNT_W, default 8, width of each saturating activity counter (legal 2..16).
REQ-002 CLK  input  1  single clock for all registered logic; the datapath is not clocked.
REQ-003 RST_N  input  1  reset, asynchronous assert, synchronous deassert to CLK, active-low.
REQ-004 IO_ISOL_N  input  1  isolation control; 0 = isolated (forced input mode), 1 = normal.
REQ-005 FPGA_DIR  input  1  direction requested by fabric; 1 = input (SOC->FPGA), 0 = output (FPGA->SOC).
REQ-006 FPGA_OUT  input  1  data from fabric toward SoC pad.
REQ-007 SOC_IN  input  1  data from SoC pad toward fabric.
REQ-008 CNT_CLR  input  1  synchronous clear of all counters and sticky flags.
REQ-009 FPGA_IN  output  1  tri-statable data to fabric.
REQ-010 SOC_OUT  output  1  tri-statable data to SoC pad.
REQ-011 SOC_DIR  output  1  effective pad direction; 1 = input, 0 = output.
REQ-012 MODE  output  2  registered mode: 2'b00 isolated, 2'b01 input, 2'b10 output; 2'b11 unused.
REQ-013 DIR_CHG_CNT  output  CNT_W  saturating count of clock samples where the effective direction changed.
REQ-014 IN_TGL_CNT  output  CNT_W  saturating count of SOC_IN toggles sampled while in input mode.
REQ-015 OUT_TGL_CNT  output  CNT_W  saturating count of FPGA_OUT toggles sampled while in output mode.
REQ-016 SAT  output  1  sticky flag, set when any counter reaches all-ones.

Function
REQ-017 Effective isolation ISO = (IO_ISOL_N == 0) OR (RST_N == 0); the datapath shall be purely combinational, with zero clock latency.
REQ-018 SOC_DIR shall be 1 when ISO, else equal FPGA_DIR.
REQ-019 FPGA_IN shall equal SOC_IN when SOC_DIR == 1, else high-impedance (Z).
REQ-020 SOC_OUT shall equal FPGA_OUT when SOC_DIR == 0, else Z.
REQ-021 FPGA_IN and SOC_OUT shall never both be driven; exactly one of them is Z at every instant.
REQ-022 X or Z on FPGA_DIR with ISO false shall propagate X to SOC_DIR; ISO true shall force SOC_DIR = 1 regardless of FPGA_DIR.
REQ-023 MODE shall be updated every CLK rising edge:
  - 00 if ISO,
  - else 01 if FPGA_DIR == 1,
  - else 10.
REQ-024 Registered copies of SOC_DIR, SOC_IN and FPGA_OUT (prev samples) shall be kept for edge detection.
REQ-025 DIR_CHG_CNT shall increment by 1 on a CLK edge where the sampled SOC_DIR differs from its previous sample.
REQ-026 IN_TGL_CNT shall increment by 1 on a CLK edge where SOC_DIR == 1 and the sampled SOC_IN differs from its previous sample.
REQ-027 OUT_TGL_CNT shall increment by 1 on a CLK edge where SOC_DIR == 0 and the sampled FPGA_OUT differs from its previous sample.
REQ-028 Each counter shall saturate at 2^CNT_W-1 and never wrap.
REQ-029 SAT shall be set on the edge at which any counter becomes all-ones, and shall remain set until reset or CNT_CLR.
REQ-030 CNT_CLR = 1 shall zero all counters and SAT on that edge; CNT_CLR has priority over increments in the same cycle.
REQ-031 Previous-sample registers shall keep updating during CNT_CLR, so no spurious count occurs after clear.

Reset
REQ-032 While RST_N = 0, all of the following shall hold:
  - MODE = 00;
  - all counters = 0; SAT = 0;
  - prev SOC_DIR = 1; prev SOC_IN = 0; prev FPGA_OUT = 0;
  - datapath in isolated mode: SOC_DIR = 1, FPGA_IN = SOC_IN, SOC_OUT = Z.
REQ-033 Reset asserted mid-operation shall take effect immediately, without waiting for CLK.
REQ-034 The first edge after RST_N rises shall sample normally, with no count generated by the reset values.

Verification
REQ-035 Isolation: RST_N=1, IO_ISOL_N=0, FPGA_DIR toggling -> SOC_DIR=1, FPGA_IN=SOC_IN, SOC_OUT=Z, MODE=00 at every edge.
REQ-036 Input mode: IO_ISOL_N=1, FPGA_DIR=1, SOC_IN toggling every 2 clocks -> FPGA_IN=SOC_IN, SOC_OUT=Z, MODE=01, IN_TGL_CNT increments once per toggle.
REQ-037 Output mode: IO_ISOL_N=1, FPGA_DIR=0, FPGA_OUT toggling -> SOC_OUT=FPGA_OUT, FPGA_IN=Z, SOC_DIR=0, MODE=10, OUT_TGL_CNT counts toggles.
REQ-038 Direction swing: FPGA_DIR inverted every 4 clocks for 10 clocks with IO_ISOL_N=1 -> DIR_CHG_CNT = number of inversions, and FPGA_IN/SOC_OUT are never both driven.
REQ-039 Saturation/clear: CNT_W=2, 5 SOC_IN toggles in input mode -> IN_TGL_CNT=3, SAT=1; then CNT_CLR=1 for one edge -> all counters 0, SAT=0.
REQ-040 Async reset: RST_N driven to 0 between edges in output mode -> SOC_DIR=1 and SOC_OUT=Z immediately, MODE=00 and counters 0 before the next CLK edge.

Source files
------------

// File: rtl/embedded_io_hd_cell.sv
`default_nettype none
// ============================================================================
// Module   : embedded_io_hd_cell
// Brief    : Bidirectional FPGA<->SoC I/O cell with isolation and activity counters.
// Revision : 1.0  initial release
// ============================================================================
module embedded_io_hd_cell #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             io_isol_n_i,
    input  logic             fpga_dir_i,
    input  logic             fpga_out_i,
    input  logic             soc_in_i,
    input  logic             cnt_clr_i,
    output wire              fpga_in_o,
    output wire              soc_out_o,
    output logic             soc_dir_o,
    output logic [1:0]       mode_o,
    output logic [CNT_W-1:0] dir_chg_cnt_o,
    output logic [CNT_W-1:0] in_tgl_cnt_o,
    output logic [CNT_W-1:0] out_tgl_cnt_o,
    output logic             sat_o
);

    localparam logic [1:0]       MODE_ISO = 2'b00;
    localparam logic [1:0]       MODE_IN  = 2'b01;
    localparam logic [1:0]       MODE_OUT = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             iso;
    logic             soc_dir;

    logic [1:0]       mode_q,     mode_d;
    logic [CNT_W-1:0] dir_cnt_q,  dir_cnt_d;
    logic [CNT_W-1:0] in_cnt_q,   in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic             sat_q,      sat_d;
    logic             soc_dir_q;
    logic             soc_in_q;
    logic             fpga_out_q;
    // Low for the first edge after reset so the reset values of the
    // previous-sample registers never produce a count.
    logic             primed_q;

    logic             dir_chg;
    logic             in_tgl;
    logic             out_tgl;

    function automatic logic [CNT_W-1:0] f_cnt_next(
        input logic             clr,
        input logic             inc,
        input logic [CNT_W-1:0] cur
    );
        if (clr)
            return '0;
        else if (inc && (cur != CNT_MAX))
            return cur + CNT_ONE;
        else
            return cur;
    endfunction

    // Unclocked datapath: reset acts as isolation with zero latency.
    assign iso       = ~io_isol_n_i | ~rst_n_i;
    assign soc_dir   = iso ? 1'b1 : fpga_dir_i;
    assign soc_dir_o = soc_dir;
    assign fpga_in_o = soc_dir          ? soc_in_i   : 1'bz;
    assign soc_out_o = (soc_dir == 1'b0) ? fpga_out_i : 1'bz;

    always_comb begin
        dir_chg   = primed_q & (soc_dir != soc_dir_q);
        in_tgl    = primed_q & soc_dir & (soc_in_i != soc_in_q);
        out_tgl   = primed_q & ~soc_dir & (fpga_out_i != fpga_out_q);

        dir_cnt_d = f_cnt_next(cnt_clr_i, dir_chg, dir_cnt_q);
        in_cnt_d  = f_cnt_next(cnt_clr_i, in_tgl,  in_cnt_q);
        out_cnt_d = f_cnt_next(cnt_clr_i, out_tgl, out_cnt_q);

        if (cnt_clr_i)
            sat_d = 1'b0;
        else
            sat_d = sat_q | (dir_cnt_d == CNT_MAX) | (in_cnt_d == CNT_MAX)
                          | (out_cnt_d == CNT_MAX);

        mode_d = MODE_OUT;
        if (iso)
            mode_d = MODE_ISO;
        else if (fpga_dir_i == 1'b1)
            mode_d = MODE_IN;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q     <= MODE_ISO;
            dir_cnt_q  <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            sat_q      <= 1'b0;
            soc_dir_q  <= 1'b1;
            soc_in_q   <= 1'b0;
            fpga_out_q <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            dir_cnt_q  <= dir_cnt_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            sat_q      <= sat_d;
            soc_dir_q  <= soc_dir;
            soc_in_q   <= soc_in_i;
            fpga_out_q <= fpga_out_i;
            primed_q   <= 1'b1;
        end
    end

    assign mode_o        = mode_q;
    assign dir_chg_cnt_o = dir_cnt_q;
    assign in_tgl_cnt_o  = in_cnt_q;
    assign out_tgl_cnt_o = out_cnt_q;
    assign sat_o         = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_embedded_io_hd_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_embedded_io_hd_cell
// Brief    : Directed vector bench for embedded_io_hd_cell; tri-state pins are
//            pulled up, so a released pin reads 1 while a driven one follows data.
// Revision : 1.0  initial release
// ============================================================================
module tb_embedded_io_hd_cell;

    logic clk = 1'b0;
    logic rst_n, isol_n, fdir, fout, sin, clr;

    wire        fin, sout, sdir;
    wire  [1:0] mode;
    wire  [7:0] dcnt, icnt, ocnt;
    wire        sat;

    wire        s_fin, s_sout, s_sdir;
    wire  [1:0] s_mode;
    wire  [1:0] s_dcnt, s_icnt, s_ocnt;
    wire        s_sat;

    pullup (fin);
    pullup (sout);
    pullup (s_fin);
    pullup (s_sout);

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    embedded_io_hd_cell #(.CNT_W(8)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .io_isol_n_i(isol_n), .fpga_dir_i(fdir),
        .fpga_out_i(fout), .soc_in_i(sin), .cnt_clr_i(clr),
        .fpga_in_o(fin), .soc_out_o(sout), .soc_dir_o(sdir), .mode_o(mode),
        .dir_chg_cnt_o(dcnt), .in_tgl_cnt_o(icnt), .out_tgl_cnt_o(ocnt), .sat_o(sat)
    );

    embedded_io_hd_cell #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .io_isol_n_i(isol_n), .fpga_dir_i(fdir),
        .fpga_out_i(fout), .soc_in_i(sin), .cnt_clr_i(clr),
        .fpga_in_o(s_fin), .soc_out_o(s_sout), .soc_dir_o(s_sdir), .mode_o(s_mode),
        .dir_chg_cnt_o(s_dcnt), .in_tgl_cnt_o(s_icnt), .out_tgl_cnt_o(s_ocnt), .sat_o(s_sat)
    );

    // fields: rst_n isol_n dir fout sin | exp soc_dir, exp fpga_in pin, exp soc_out pin
    typedef struct packed {
        logic rst_n, isol_n, dir, fout, sin;
        logic e_dir, e_fin, e_sout;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int d, input int i, input int o, input int s);
        chk({tag, ".dir_chg"}, int'(dcnt), d);
        chk({tag, ".in_tgl"},  int'(icnt), i);
        chk({tag, ".out_tgl"}, int'(ocnt), o);
        chk({tag, ".sat"},     int'(sat),  s);
    endtask

    initial begin
        tbl[0]  = 8'b0_1_0_0_1_1_1_1;   // reset forces isolation despite dir=0
        tbl[1]  = 8'b0_1_0_0_0_1_0_1;
        tbl[2]  = 8'b1_0_0_0_1_1_1_1;   // isolated
        tbl[3]  = 8'b1_0_0_0_0_1_0_1;
        tbl[4]  = 8'b1_0_1_1_0_1_0_1;
        tbl[5]  = 8'b1_1_1_0_1_1_1_1;   // input mode
        tbl[6]  = 8'b1_1_1_0_0_1_0_1;
        tbl[7]  = 8'b1_1_1_1_0_1_0_1;
        tbl[8]  = 8'b1_1_0_1_0_0_1_1;   // output mode
        tbl[9]  = 8'b1_1_0_0_0_0_1_0;
        tbl[10] = 8'b1_1_0_0_1_0_1_0;
        tbl[11] = 8'b1_1_0_1_1_0_1_1;

        rst_n = 1'b0; isol_n = 1'b1; fdir = 1'b0; fout = 1'b0; sin = 1'b0; clr = 1'b0;
        #12;
        chk("rst.mode", int'(mode), 0);
        chk_cnts("rst", 0, 0, 0, 0);
        chk("rst.soc_dir", int'(sdir), 1);
        chk("rst.fpga_in", int'(fin), 0);
        chk("rst.soc_out_z", int'(sout), 1);

        for (int i = 0; i < 12; i++) begin
            rst_n = tbl[i].rst_n; isol_n = tbl[i].isol_n; fdir = tbl[i].dir;
            fout = tbl[i].fout; sin = tbl[i].sin;
            #1;
            chk($sformatf("vec%0d.soc_dir", i), int'(sdir), int'(tbl[i].e_dir));
            chk($sformatf("vec%0d.fpga_in", i), int'(fin),  int'(tbl[i].e_fin));
            chk($sformatf("vec%0d.soc_out", i), int'(sout), int'(tbl[i].e_sout));
        end

        // Clean restart, reset released between edges.
        rst_n = 1'b0; isol_n = 1'b0; fdir = 1'b0; fout = 1'b0; sin = 1'b0;
        step(); step();
        #3 rst_n = 1'b1;

        // Isolation with FPGA_DIR toggling.
        for (int k = 0; k < 4; k++) begin
            fdir = k[0];
            step();
            chk($sformatf("iso%0d.mode", k), int'(mode), 0);
            chk($sformatf("iso%0d.soc_dir", k), int'(sdir), 1);
            chk($sformatf("iso%0d.soc_out_z", k), int'(sout), 1);
        end
        chk_cnts("iso", 0, 0, 0, 0);

        // Input mode, SOC_IN toggling every 2 clocks.
        isol_n = 1'b1; fdir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sin = ((k / 2) % 2) != 0;
            step();
            chk($sformatf("in%0d.mode", k), int'(mode), 1);
            chk($sformatf("in%0d.fpga_in", k), int'(fin), int'(sin));
        end
        chk_cnts("in", 0, 3, 0, 0);

        // Output mode, FPGA_OUT toggling every clock.
        fdir = 1'b0;
        for (int k = 0; k < 6; k++) begin
            fout = k[0];
            if (k == 0) sin = 1'b0;
            step();
            chk($sformatf("out%0d.mode", k), int'(mode), 2);
            chk($sformatf("out%0d.soc_out", k), int'(sout), int'(fout));
            chk($sformatf("out%0d.fpga_in_z", k), int'(fin), 1);
            chk($sformatf("out%0d.soc_dir", k), int'(sdir), 0);
        end
        chk_cnts("out", 1, 3, 5, 0);

        // Direction swing: inverted every 4 clocks, both data sources low.
        fout = 1'b0;
        for (int k = 0; k < 10; k++) begin
            fdir = (((k / 4) + 1) % 2) != 0;
            #1;
            chk($sformatf("swing%0d.excl", k), int'(fin ^ sout), 1);
            chk($sformatf("swing%0d.fpga_in", k), int'(fin), fdir ? 0 : 1);
            step();
        end
        chk("swing.mode", int'(mode), 1);
        chk_cnts("swing", 4, 3, 5, 0);

        // Clear, then saturate the narrow instance.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_cnts("clr1", 0, 0, 0, 0);
        chk("clr1.s_in", int'(s_icnt), 0);
        chk("clr1.s_sat", int'(s_sat), 0);
        for (int k = 0; k < 5; k++) begin
            sin = ~sin;
            step();
        end
        chk("satr.s_in", int'(s_icnt), 3);
        chk("satr.s_sat", int'(s_sat), 1);
        chk("satr.s_dir", int'(s_dcnt), 0);
        chk_cnts("satr", 0, 5, 0, 0);

        // Clear wins over a coincident toggle; no count afterwards.
        sin = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr2.s_in", int'(s_icnt), 0);
        chk("clr2.s_sat", int'(s_sat), 0);
        chk_cnts("clr2", 0, 0, 0, 0);
        step();
        chk("post.s_in", int'(s_icnt), 0);
        chk_cnts("post", 0, 0, 0, 0);

        // Async reset in output mode, asserted between edges.
        fdir = 1'b0;
        step();
        fout = 1'b1;
        step();
        chk_cnts("pre", 1, 0, 1, 0);
        chk("pre.mode", int'(mode), 2);
        #2 fout = 1'b0; rst_n = 1'b0;
        #1;
        chk("arst.soc_dir", int'(sdir), 1);
        chk("arst.soc_out_z", int'(sout), 1);
        chk("arst.fpga_in", int'(fin), 0);
        chk("arst.mode", int'(mode), 0);
        chk_cnts("arst", 0, 0, 0, 0);

        // Release with inputs that differ from the reset prev-values.
        #2 fout = 1'b1; sin = 1'b1; rst_n = 1'b1;
        step();
        chk("rel.mode", int'(mode), 2);
        chk_cnts("rel", 0, 0, 0, 0);
        fout = 1'b0;
        step();
        chk_cnts("rel2", 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
